// File: rtl/udp_tx_pkt_ctrl.sv
// UDP transmit read-out controller: queues packet lengths, starts the transmitter and feeds it
// FIFO bytes on request. Optional minimum-length padding under `UDP_TX_MIN_LEN_PAD_EN.
module udp_tx_pkt_ctrl #(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned LENQ_AW    = 2,
  parameter int unsigned GAP_CYCLES = 12,
  parameter int unsigned MIN_LEN    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             len_wr,
  input  logic [LEN_W-1:0] len_in,
  output logic             len_full,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_empty,
  output logic             tx_start_en,
  output logic [LEN_W-1:0] tx_byte_num,
  input  logic             tx_req,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned Depth = 2 ** LENQ_AW;
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StStart, StSend, StWaitDone, StDrain, StGap} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   q_mem [Depth];
  logic [LENQ_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LENQ_AW:0]   q_cnt_q;
  logic [LEN_W-1:0]   cur_len_q, out_len_q, byte_cnt_q;
  logic [GapW-1:0]    gap_cnt_q;
  logic               start_q, rd_flag_q, underrun_q;

  logic             push, pop;
  logic [LEN_W-1:0] pop_len, pop_out_len, byte_nxt;
  logic             byte_lt_cur, send_req, send_rd, drain_rd;

  assign len_full    = (q_cnt_q == (LENQ_AW + 1)'(Depth));
  assign push        = len_wr && !len_full;
  assign pop         = (state_q == StIdle) && (q_cnt_q != '0);
  assign pop_len     = q_mem[rd_ptr_q];

`ifdef UDP_TX_MIN_LEN_PAD_EN
  assign pop_out_len = (pop_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : pop_len;
`else
  assign pop_out_len = pop_len;
`endif

  // byte_cnt stays below out_len while counting, so the increment cannot wrap
  assign byte_nxt    = byte_cnt_q + 1'b1;
  assign byte_lt_cur = (byte_cnt_q < cur_len_q);
  assign send_req    = (state_q == StSend) && tx_req && !tx_done;
  assign send_rd     = send_req && byte_lt_cur && !fifo_empty;
  assign drain_rd    = (state_q == StDrain) && byte_lt_cur && !fifo_empty;

  assign fifo_rd_en  = send_rd || drain_rd;
  assign tx_start_en = start_q;
  assign tx_byte_num = out_len_q;
  assign tx_data     = rd_flag_q ? fifo_rd_data : 8'h00;
  assign busy        = (state_q != StIdle);
  assign underrun    = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) q_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
    end else begin
      if (push) begin
        q_mem[wr_ptr_q] <= len_in;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      q_cnt_q <= q_cnt_q + 1'b1;
      else if (!push && pop) q_cnt_q <= q_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_len_q  <= '0;
      out_len_q  <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      start_q    <= 1'b0;
      rd_flag_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      rd_flag_q <= send_rd;
      if (send_req && byte_lt_cur && fifo_empty) underrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            cur_len_q <= pop_len;
            // zero-length entries are dropped without disturbing the transmitter
            if (pop_len != '0) begin
              out_len_q <= pop_out_len;
              start_q   <= 1'b1;
              state_q   <= StStart;
            end
          end
        end
        StStart: begin
          byte_cnt_q <= '0;
          state_q    <= StSend;
        end
        StSend: begin
          if (tx_done) begin
            if (byte_lt_cur) begin
              state_q <= StDrain;
            end else begin
              gap_cnt_q <= GapW'(GAP_CYCLES);
              state_q   <= StGap;
            end
          end else if (tx_req) begin
            byte_cnt_q <= byte_nxt;
            if (byte_nxt == out_len_q) state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (tx_done) begin
            gap_cnt_q <= GapW'(GAP_CYCLES);
            state_q   <= StGap;
          end
        end
        StDrain: begin
          if (drain_rd) begin
            byte_cnt_q <= byte_nxt;
            if (byte_nxt == cur_len_q) begin
              gap_cnt_q <= GapW'(GAP_CYCLES);
              state_q   <= StGap;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q <= GapW'(1)) state_q <= StIdle;
          else gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_pkt_ctrl.sv
// Self-checking bench for udp_tx_pkt_ctrl: table of packet vectors plus hand-written sequences
// for zero-length drop, full length queue, drain after early tx_done and mid-packet reset.
module tb_udp_tx_pkt_ctrl;
  localparam int LEN_W = 16;
  localparam int G     = 12;
`ifdef UDP_TX_MIN_LEN_PAD_EN
  localparam bit PadOn = 1'b1;
`else
  localparam bit PadOn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             len_wr = 1'b0;
  logic [LEN_W-1:0] len_in = '0;
  logic             len_full, fifo_rd_en, fifo_empty, tx_start_en, busy, underrun;
  logic [7:0]       fifo_rd_data, tx_data;
  logic [LEN_W-1:0] tx_byte_num;
  logic             tx_req = 1'b0;
  logic             tx_done = 1'b0;

  always #5 clk = ~clk;

  udp_tx_pkt_ctrl #(
    .LEN_W(LEN_W), .LENQ_AW(2), .GAP_CYCLES(G), .MIN_LEN(18)
  ) dut (
    .clk(clk), .rst_n(rst_n), .len_wr(len_wr), .len_in(len_in), .len_full(len_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .underrun(underrun)
  );

  // FIFO model: one-cycle read latency, flushed with the DUT reset
  logic [7:0] fmem [2048];
  int fwr = 0;
  int frd = 0;
  assign fifo_empty = (fwr == frd);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frd          <= fwr;
      fifo_rd_data <= 8'h00;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[frd % 2048];
      frd          <= frd + 1;
    end
  end

  int cyc = 0, rd_cnt = 0, start_cnt = 0, rd_empty_cnt = 0;
  int last_rd = 0, last_done = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= cyc;
      if (fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
    end
    if (tx_start_en) start_cnt <= start_cnt + 1;
    if (tx_done) last_done <= cyc;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pad(input int l);
    return (PadOn && l < 18) ? 18 : l;
  endfunction

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[fwr % 2048] = base + 8'(i);
      fwr++;
    end
  endtask

  task automatic push_len(input int l);
    len_wr = 1'b1;
    len_in = LEN_W'(l);
    @(negedge clk);
    len_wr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max && busy; k++) @(negedge clk);
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start(input int max);
    for (int k = 0; k < max && !tx_start_en; k++) @(negedge clk);
    chk("start_seen", {31'd0, tx_start_en}, 32'd1);
  endtask

  // Called at the negedge where tx_start_en is high
  task automatic serve(input int num, input int len, input int avail, input logic [7:0] base,
                       input int nreq, input bit do_done);
    logic [7:0] e;
    chk("tx_byte_num", 32'(tx_byte_num), 32'(num));
    @(negedge clk);
    for (int i = 0; i < nreq; i++) begin
      tx_req = 1'b1;
      @(negedge clk);
      e = (i < len && i < avail) ? base + 8'(i) : 8'h00;
      chk("tx_data", 32'(tx_data), 32'(e));
    end
    tx_req = 1'b0;
    if (do_done) begin
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  typedef struct {
    int         len;
    int         avail;
    logic [7:0] base;
    int         num;
    int         reads;
    bit         ur;
  } vec_t;

  vec_t vecs[5];
  int   rd0, s0;

  initial begin
    vecs[0] = '{4, 4, 8'hA0, PadOn ? 18 : 4, 4, 1'b0};
    vecs[1] = '{1, 1, 8'hB0, PadOn ? 18 : 1, 1, 1'b0};
    vecs[2] = '{7, 7, 8'hC0, PadOn ? 18 : 7, 7, 1'b0};
    vecs[3] = '{5, 5, 8'hD0, PadOn ? 18 : 5, 5, 1'b0};
    vecs[4] = '{8, 3, 8'hE0, PadOn ? 18 : 8, 3, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("rst_tx_start_en", {31'd0, tx_start_en}, 0);
    chk("rst_tx_byte_num", 32'(tx_byte_num), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_len_full", {31'd0, len_full}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      wait_idle(100);
      load(vecs[v].base, vecs[v].avail);
      rd0 = rd_cnt;
      s0  = start_cnt;
      push_len(vecs[v].len);
      @(negedge clk);
      chk("start_latency", {31'd0, tx_start_en}, 1);
      serve(vecs[v].num, vecs[v].len, vecs[v].avail, vecs[v].base, vecs[v].num, 1'b1);
      wait_idle(100);
      chk("reads", 32'(rd_cnt - rd0), 32'(vecs[v].reads));
      chk("starts", 32'(start_cnt - s0), 1);
      chk("underrun", {31'd0, underrun}, {31'd0, vecs[v].ur});
      chk("fifo_empty", {31'd0, fifo_empty}, 1);
    end

    // Zero-length entry is dropped, the following one starts
    load(8'h30, 2);
    s0 = start_cnt;
    push_len(0);
    push_len(2);
    wait_start(10);
    chk("zero_len_no_start", 32'(start_cnt - s0), 0);
    serve(pad(2), 2, 2, 8'h30, pad(2), 1'b1);
    wait_idle(100);
    chk("zero_len_starts", 32'(start_cnt - s0), 1);

    // Fill the length queue while the transmitter holds a packet in WAIT_DONE
    load(8'h50, 5);
    s0 = start_cnt;
    push_len(1);
    wait_start(10);
    serve(pad(1), 1, 1, 8'h50, pad(1), 1'b0);
    for (int k = 1; k <= 4; k++) begin
      push_len(1);
      chk("len_full_fill", {31'd0, len_full}, (k == 4) ? 32'd1 : 32'd0);
    end
    push_len(1);
    chk("len_full_overflow", {31'd0, len_full}, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_start(40);
      if (k == 0) chk("gap_after_done", 32'(cyc - last_done), 32'(G + 2));
      serve(pad(1), 1, 1, 8'h51 + 8'(k), pad(1), 1'b1);
    end
    repeat (40) @(negedge clk);
    chk("full_starts", 32'(start_cnt - s0), 5);
    chk("full_idle", {31'd0, busy}, 0);
    chk("full_fifo_empty", {31'd0, fifo_empty}, 1);

    // Early tx_done: remaining bytes are drained, next start after the gap
    load(8'h70, 11);
    rd0 = rd_cnt;
    push_len(10);
    wait_start(10);
    serve(pad(10), 10, 11, 8'h70, 4, 1'b1);
    push_len(1);
    wait_start(60);
    chk("drain_reads", 32'(rd_cnt - rd0), 10);
    chk("drain_gap", 32'(cyc - last_rd), 32'(G + 2));
    serve(pad(1), 1, 1, 8'h7A, pad(1), 1'b1);
    wait_idle(100);
    chk("drain_fifo_empty", {31'd0, fifo_empty}, 1);
    chk("rd_while_empty", 32'(rd_empty_cnt), 0);

    // Reset mid-packet returns to IDLE at once and clears underrun
    load(8'h90, 3);
    push_len(3);
    wait_start(10);
    @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    chk("midpkt_busy", {31'd0, busy}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_underrun", {31'd0, underrun}, 0);
    chk("midrst_tx_byte_num", 32'(tx_byte_num), 0);
    chk("midrst_fifo_rd_en", {31'd0, fifo_rd_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
